// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
package mem_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RN_W = 5;

  localparam logic [XLEN-1:0] MEM_TIMEOUT_DATA = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/pipeline_reg.sv
// Generic pipeline register with stall (hold) and bubble (inject BUBBLE_V).
module pipeline_reg #(
  parameter int unsigned   W        = 32,
  parameter logic [W-1:0]  BUBBLE_V = '0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         stall,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Bubble wins over stall so a stalled producer never leaks a stale value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q <= '0;
    end else if (bubble) begin
      r_q <= BUBBLE_V;
    end else if (!stall) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: runs one data-bus access per load/store and feeds W.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            m_wreg,
  input  logic            m_m2reg,
  input  logic            m_wmem,
  input  logic [XLEN-1:0] m_data,
  input  logic [XLEN-1:0] m_memin,
  input  logic [RN_W-1:0] m_rn,
  output logic            m_busy,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            w_wreg,
  output logic [RN_W-1:0] w_rn,
  output logic [XLEN-1:0] w_data,
  output logic            mem_err
);

  mem_state_e      r_state;
  mem_state_e      w_state_nxt;

  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [XLEN-1:0] r_dmem_addr;
  logic [XLEN-1:0] r_dmem_wdata;
  logic [XLEN-1:0] r_hold;

  logic            w_access;
  logic            w_load;
  logic            w_timeout;
  logic            w_wb_wreg;
  logic [RN_W-1:0] w_wb_rn;
  logic [XLEN-1:0] w_wb_data;

  assign w_access = m_wmem | (m_wreg & m_m2reg);
  assign w_load   = m_wreg & m_m2reg & ~m_wmem;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  // Expires on the TIMEOUT_CYCLES-th ACCESS cycle without an ack.
  assign w_timeout = (r_state == ST_ACCESS) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if ((r_state == ST_ACCESS) && !dmem_ack && !w_timeout) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_timeout && !dmem_ack) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  assign mem_err = r_mem_err;
`else
  assign w_timeout = 1'b0;
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, stall request and W-stage payload.
  always_comb begin
    w_state_nxt = r_state;
    m_busy      = 1'b0;
    w_wb_wreg   = m_wreg;
    w_wb_rn     = m_rn;
    w_wb_data   = m_data;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          m_busy      = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        m_busy = 1'b1;
        if (dmem_ack || w_timeout) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_wb_wreg   = m_wreg & ~m_wmem;
        w_wb_data   = w_load ? r_hold : m_data;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bus request is launched on entry to ACCESS and held until completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_ACCESS)) begin
      r_dmem_req   <= 1'b1;
      r_dmem_we    <= m_wmem;
      r_dmem_addr  <= m_data;
      r_dmem_wdata <= m_memin;
    end else if ((r_state == ST_ACCESS) && (w_state_nxt == ST_DONE)) begin
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
    end
  end

  // Ack has priority over a coincident timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hold <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (dmem_ack) begin
        r_hold <= dmem_rdata;
      end else if (w_timeout) begin
        r_hold <= MEM_TIMEOUT_DATA;
      end
    end
  end

  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;

  pipeline_reg #(.W(1), .BUBBLE_V(1'b0)) u_w_wreg (
    .clk    (clk),
    .resetn (resetn),
    .stall  (1'b0),
    .bubble (m_busy),
    .d      (w_wb_wreg),
    .q      (w_wreg)
  );

  pipeline_reg #(.W(RN_W), .BUBBLE_V('0)) u_w_rn (
    .clk    (clk),
    .resetn (resetn),
    .stall  (1'b0),
    .bubble (m_busy),
    .d      (w_wb_rn),
    .q      (w_rn)
  );

  pipeline_reg #(.W(XLEN), .BUBBLE_V('0)) u_w_data (
    .clk    (clk),
    .resetn (resetn),
    .stall  (1'b0),
    .bubble (m_busy),
    .d      (w_wb_data),
    .q      (w_data)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; timeout scenarios run when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_wreg, m_m2reg, m_wmem;
  logic [31:0] m_data, m_memin;
  logic [4:0]  m_rn;
  logic        m_busy;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        w_wreg;
  logic [4:0]  w_rn;
  logic [31:0] w_data;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m_wreg     (m_wreg),
    .m_m2reg    (m_m2reg),
    .m_wmem     (m_wmem),
    .m_data     (m_data),
    .m_memin    (m_memin),
    .m_rn       (m_rn),
    .m_busy     (m_busy),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .w_wreg     (w_wreg),
    .w_rn       (w_rn),
    .w_data     (w_data),
    .mem_err    (mem_err)
  );

  // Presents one instruction until the stage stops stalling; acks the (waits+1)-th request cycle.
  task automatic mem_op(input logic wreg, input logic m2reg, input logic wmem,
                        input logic [31:0] data, input logic [31:0] memin, input logic [4:0] rn,
                        input int waits, input logic [31:0] rdata,
                        output int busy_n, output int req_n, output int wb_n,
                        output logic [31:0] wb_data, output logic [4:0] wb_rn,
                        output logic [31:0] addr_s, output logic [31:0] wdata_s,
                        output logic we_s, output logic stable, output logic done);
    busy_n = 0; req_n = 0; wb_n = 0;
    wb_data = '0; wb_rn = '0; addr_s = '0; wdata_s = '0;
    we_s = 1'b0; stable = 1'b1; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      m_wreg = wreg; m_m2reg = m2reg; m_wmem = wmem;
      m_data = data; m_memin = memin; m_rn = rn;
      dmem_ack = 1'b0; dmem_rdata = 32'h0BAD0BAD;
      #1;
      if (dmem_req) begin
        if (req_n == 0) begin
          addr_s = dmem_addr; wdata_s = dmem_wdata; we_s = dmem_we;
        end else if ({dmem_addr, dmem_wdata, dmem_we} !== {addr_s, wdata_s, we_s}) begin
          stable = 1'b0;
        end
        if (req_n == waits) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
        end
        req_n++;
      end
      if (m_busy) busy_n++;
      else done = 1'b1;
      @(posedge clk); #1;
      if (w_wreg) wb_n++;
      wb_data = w_data; wb_rn = w_rn;
    end
    m_wreg = 1'b0; m_m2reg = 1'b0; m_wmem = 1'b0; dmem_ack = 1'b0;
  endtask

  int          busy_n, req_n, wb_n;
  logic [31:0] wb_data, addr_s, wdata_s;
  logic [4:0]  wb_rn;
  logic        we_s, stable, done;

  task automatic test_reset();
    resetn = 1'b0;
    m_wreg = 1'b0; m_m2reg = 1'b0; m_wmem = 1'b0;
    m_data = '0; m_memin = '0; m_rn = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dmem_req, dmem_we, w_wreg, mem_err, m_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {dmem_req, dmem_we, w_wreg, mem_err, m_busy});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, w_data, w_rn} !== '0) begin
      errors++; $display("FAIL reset_buses: addr=%h wdata=%h w_data=%h w_rn=%0d expected all 0", dmem_addr, dmem_wdata, w_data, w_rn);
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    mem_op(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if (busy_n !== 0 || req_n !== 0 || done !== 1'b1) begin
      errors++; $display("FAIL alu_busy: busy=%0d req=%0d done=%b expected 0 0 1", busy_n, req_n, done);
    end
    checks++;
    if ({wb_n, wb_rn, wb_data} !== {32'd1, 5'd5, 32'h1234}) begin
      errors++; $display("FAIL alu_wb: n=%0d rn=%0d data=%h expected 1 5 00001234", wb_n, wb_rn, wb_data);
    end
    mem_op(1'b0, 1'b0, 1'b0, 32'hFFFF, 32'h0, 5'd9, 0, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({wb_n, wb_rn, wb_data} !== {32'd0, 5'd9, 32'hFFFF}) begin
      errors++; $display("FAIL nowrite_wb: n=%0d rn=%0d data=%h expected 0 9 0000ffff", wb_n, wb_rn, wb_data);
    end
  endtask

  task automatic test_load();
    mem_op(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 2, 32'hCAFEF00D,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if (done !== 1'b1 || busy_n !== 4 || req_n !== 3) begin
      errors++; $display("FAIL load_latency: done=%b busy=%0d req=%0d expected 1 4 3", done, busy_n, req_n);
    end
    checks++;
    if (addr_s !== 32'h100 || we_s !== 1'b0 || stable !== 1'b1) begin
      errors++; $display("FAIL load_bus: addr=%h we=%b stable=%b expected 00000100 0 1", addr_s, we_s, stable);
    end
    checks++;
    if ({wb_n, wb_rn, wb_data} !== {32'd1, 5'd7, 32'hCAFEF00D}) begin
      errors++; $display("FAIL load_wb: n=%0d rn=%0d data=%h expected 1 7 cafef00d", wb_n, wb_rn, wb_data);
    end
  endtask

  task automatic test_store();
    mem_op(1'b0, 1'b0, 1'b1, 32'h200, 32'hA5A5A5A5, 5'd2, 0, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if (busy_n !== 2 || req_n !== 1) begin
      errors++; $display("FAIL store_latency: busy=%0d req=%0d expected 2 1", busy_n, req_n);
    end
    checks++;
    if ({addr_s, wdata_s, we_s} !== {32'h200, 32'hA5A5A5A5, 1'b1}) begin
      errors++; $display("FAIL store_bus: addr=%h wdata=%h we=%b expected 00000200 a5a5a5a5 1", addr_s, wdata_s, we_s);
    end
    checks++;
    if (wb_n !== 0 || wb_data !== 32'h200) begin
      errors++; $display("FAIL store_wb: n=%0d data=%h expected 0 00000200", wb_n, wb_data);
    end
  endtask

  task automatic test_stray_ack();
    m_wreg = 1'b1; m_m2reg = 1'b0; m_wmem = 1'b0;
    m_data = 32'h55; m_rn = 5'd4;
    dmem_ack = 1'b1; dmem_rdata = 32'h77777777;
    #1;
    checks++;
    if (m_busy !== 1'b0) begin
      errors++; $display("FAIL stray_busy: got %b expected 0", m_busy);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if ({dmem_req, w_wreg, w_rn, w_data} !== {1'b0, 1'b1, 5'd4, 32'h55}) begin
      errors++; $display("FAIL stray_ack: req=%b wreg=%b rn=%0d data=%h expected 0 1 4 00000055", dmem_req, w_wreg, w_rn, w_data);
    end
  endtask

  task automatic test_back_to_back();
    mem_op(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 0, 32'h11111111,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({busy_n, req_n, wb_n, wb_data} !== {32'd2, 32'd1, 32'd1, 32'h11111111}) begin
      errors++; $display("FAIL b2b_load0: busy=%0d req=%0d n=%0d data=%h expected 2 1 1 11111111", busy_n, req_n, wb_n, wb_data);
    end
    mem_op(1'b1, 1'b1, 1'b1, 32'h44, 32'h12345678, 5'd6, 0, 32'h22222222,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({busy_n, req_n, we_s, wb_n, wdata_s} !== {32'd2, 32'd1, 1'b1, 32'd0, 32'h12345678}) begin
      errors++; $display("FAIL b2b_store_prec: busy=%0d req=%0d we=%b n=%0d wdata=%h expected 2 1 1 0 12345678", busy_n, req_n, we_s, wb_n, wdata_s);
    end
    mem_op(1'b1, 1'b1, 1'b0, 32'h48, 32'h0, 5'd8, 1, 32'h33333333,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({busy_n, req_n, wb_n, wb_rn, wb_data} !== {32'd3, 32'd2, 32'd1, 5'd8, 32'h33333333}) begin
      errors++; $display("FAIL b2b_load1: busy=%0d req=%0d n=%0d rn=%0d data=%h expected 3 2 1 8 33333333", busy_n, req_n, wb_n, wb_rn, wb_data);
    end
    mem_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if (wb_n !== 0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_nodup: n=%0d req=%b expected 0 0", wb_n, dmem_req);
    end
  endtask

  task automatic test_reset_in_access();
    m_wreg = 1'b1; m_m2reg = 1'b1; m_wmem = 1'b0;
    m_data = 32'h300; m_memin = 32'h9; m_rn = 5'd11;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h300) begin
      errors++; $display("FAIL rst_access_entry: req=%b addr=%h expected 1 00000300", dmem_req, dmem_addr);
    end
    #2;
    resetn = 1'b0;
    m_wreg = 1'b0; m_m2reg = 1'b0;
    #1;
    checks++;
    if ({dmem_req, dmem_we, m_busy, w_wreg, w_rn, w_data, dmem_addr, dmem_wdata, mem_err} !== '0) begin
      errors++; $display("FAIL rst_in_access: req=%b we=%b busy=%b wreg=%b rn=%0d data=%h addr=%h wdata=%h err=%b expected all 0",
                         dmem_req, dmem_we, m_busy, w_wreg, w_rn, w_data, dmem_addr, dmem_wdata, mem_err);
    end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    mem_op(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 5'd12, 0, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({busy_n, req_n, wb_n, wb_rn, wb_data} !== {32'd0, 32'd0, 32'd1, 5'd12, 32'h99}) begin
      errors++; $display("FAIL rst_idle_after: busy=%0d req=%0d n=%0d rn=%0d data=%h expected 0 0 1 12 00000099", busy_n, req_n, wb_n, wb_rn, wb_data);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    mem_op(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd13, 3, 32'h600DF00D,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({req_n, wb_data, mem_err} !== {32'd4, 32'h600DF00D, 1'b0}) begin
      errors++; $display("FAIL to_ack_wins: req=%0d data=%h err=%b expected 4 600df00d 0", req_n, wb_data, mem_err);
    end
    mem_op(1'b1, 1'b1, 1'b0, 32'h504, 32'h0, 5'd14, 99, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if ({done, busy_n, req_n, wb_n, wb_data} !== {1'b1, 32'd5, 32'd4, 32'd1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL to_forced: done=%b busy=%0d req=%0d n=%0d data=%h expected 1 5 4 1 deadbeef", done, busy_n, req_n, wb_n, wb_data);
    end
    mem_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 0, 32'h0,
           busy_n, req_n, wb_n, wb_data, wb_rn, addr_s, wdata_s, we_s, stable, done);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("FAIL to_sticky: err=%b expected 1", mem_err);
    end
  endtask
`else
  task automatic test_no_timeout();
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL err_tied: err=%b expected 0", mem_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_stray_ack();
    test_back_to_back();
    test_reset_in_access();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: ACCESS-state cycles before forced completion; used only with MEM_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset; asynchronous, active-low.
REQ-004 m_wreg, m_m2reg, m_wmem  in  1 each  M-stage controls: register write, load, store.
REQ-005 m_data  in  32  ALU result; memory address for loads/stores, writeback data otherwise.
REQ-006 m_memin  in  32  store data.
REQ-007 m_rn  in  5  destination register number.
REQ-008 m_busy  out  1  stall request; drives the upstream M-stage stall.
REQ-009 dmem_req, dmem_we  out  1 each  data-bus request and write enable.
REQ-010 dmem_addr, dmem_wdata  out  32 each  bus address and write data.
REQ-011 dmem_rdata  in  32; dmem_ack  in  1  read data and one-cycle completion strobe.
REQ-012 w_wreg  out  1; w_rn  out  5; w_data  out  32  W-stage writeback.
REQ-013 mem_err  out  1  sticky bus-timeout flag.

Function
REQ-014 Access present = m_wmem | (m_wreg & m_m2reg); m_wmem takes precedence (dmem_we=1) when both hold.
REQ-015 FSM states IDLE, ACCESS, DONE; reset state IDLE.
REQ-016 IDLE, no access: m_busy=0; W captures w_wreg=m_wreg, w_rn=m_rn, w_data=m_data each edge.
REQ-017 IDLE, access present: m_busy=1 combinationally; next state ACCESS.
REQ-018 ACCESS: dmem_req=1, dmem_addr=m_data, dmem_wdata=m_memin, dmem_we per REQ-014; m_busy=1; all four held stable until ack.
REQ-019 ACCESS with dmem_ack=1: latch dmem_rdata into hold register; next state DONE; dmem_req deasserted from the next cycle.
REQ-020 DONE: m_busy=0, dmem_req=0; W captures w_data=(load ? hold : m_data), w_wreg=m_wreg & ~m_wmem, w_rn=m_rn; next state IDLE.
REQ-021 Whenever m_busy=1, W captures a bubble: w_wreg=0, w_rn=0, w_data=0, so no duplicate writeback occurs.
REQ-022 Minimum latency per memory instruction: 3 cycles (IDLE, ACCESS with immediate ack, DONE); each wait cycle adds 1.
REQ-023 dmem_ack outside ACCESS is ignored.
REQ-024 Back-to-back memory instructions: after DONE, the next instruction re-enters ACCESS via IDLE; no request overlaps.

Reset
REQ-025 On resetn=0, regardless of state: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, w_wreg=0, w_rn=0, w_data=0, hold=0, mem_err=0, timeout counter=0.
REQ-026 Reset during ACCESS drops dmem_req in the same cycle; the abandoned access is not retried.

Configuration
REQ-027 Macro MEM_TIMEOUT_EN defined: counter runs in ACCESS; after TIMEOUT_CYCLES cycles without ack, hold=32'hDEADBEEF, mem_err set (sticky until reset), next state DONE.
REQ-028 Macro MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; mem_err tied to 0.
REQ-029 Ack and timeout in the same cycle: the ack wins; mem_err is not set.

Structure
REQ-030 Shared package mem_stage_pkg holds the FSM state enum and constant MEM_TIMEOUT_DATA=32'hDEADBEEF.
REQ-031 W-stage registers are pipeline_reg instances (stall=0, bubble=m_busy, BUBBLE_V=0); the FSM, hold register and counter live in mem_stage.

Verification
REQ-032 Non-memory op m_wreg=1, m_data=32'h1234, m_rn=5 -> next edge w_wreg=1, w_rn=5, w_data=32'h1234; m_busy never asserted.
REQ-033 Load m_data=32'h100, ack after 2 wait cycles with rdata=32'hCAFEF00D -> dmem_req high 3 cycles, m_busy high 4 cycles; w_data=32'hCAFEF00D, w_wreg=1 exactly once.
REQ-034 Store m_data=32'h200, m_memin=32'hA5A5A5A5, immediate ack -> dmem_we=1, dmem_wdata=32'hA5A5A5A5; w_wreg stays 0.
REQ-035 Reset pulsed in ACCESS -> dmem_req=0 in the same cycle; all outputs 0; state IDLE after release.
REQ-036 MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, no ack on a load -> forced completion after 4 ACCESS cycles, w_data=32'hDEADBEEF, mem_err=1 and held.
REQ-037 MEM_TIMEOUT_EN defined, ack in the same cycle as the timeout -> real rdata written back; mem_err stays 0.
